// File: rtl/stream_neuron_pkg.sv
// rtl/stream_neuron_pkg.sv - shared encodings and constants for the stream neuron
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_HTANH    = 2'd2,
    ACT_LEAKY    = 2'd3
  } act_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    BIAS  = 3'd2,
    ACT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int LEAKY_SHIFT = 3;

  // Wide enough that NUM_INPUTS shifted products plus a bias can never overflow.
  function automatic int acc_width(input int width, input int frac_bits, input int num_inputs);
    return 2 * width - frac_bits + $clog2(num_inputs) + 1;
  endfunction

endpackage

// File: rtl/stream_neuron_if.sv
// rtl/stream_neuron_if.sv - weight port, input stream and result stream of the neuron
interface stream_neuron_if #(
  parameter int NUM_INPUTS = 8,
  parameter int WIDTH      = 8
);
  localparam int AW = $clog2(NUM_INPUTS + 1);

  logic             weight_we;
  logic [AW-1:0]    weight_addr;
  logic [WIDTH-1:0] weight_data;
  logic [1:0]       act_mode;
  logic [WIDTH-1:0] value_in;
  logic             valid_in;
  logic             ready;
  logic [WIDTH-1:0] value_out;
  logic             valid_out;
  logic             ready_out;
  logic             overflow;

  modport master (
    output weight_we, weight_addr, weight_data, act_mode, value_in, valid_in, ready_out,
    input  ready, value_out, valid_out, overflow
  );

  modport slave (
    input  weight_we, weight_addr, weight_data, act_mode, value_in, valid_in, ready_out,
    output ready, value_out, valid_out, overflow
  );
endinterface

// File: rtl/stream_neuron_fxp_mac.sv
// rtl/stream_neuron_fxp_mac.sv - fixed-point multiply, floor shift and accumulate with load/add
module fxp_mac #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int ACC_W     = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mac_en,
  input  logic                    load,
  input  logic                    add_en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [ACC_W-1:0] add_val,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic signed [ACC_W-1:0]   term;

  assign prod    = a * b;
  assign prod_sh = prod >>> FRAC_BITS;
  assign term    = ACC_W'(prod_sh);

  // The first beat of a vector loads instead of adding, so no clear cycle is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= load ? term : acc + term;
    end else if (add_en) begin
      acc <= acc + add_val;
    end
  end

endmodule

// File: rtl/stream_neuron.sv
// rtl/stream_neuron.sv - serial MAC neuron with bias and selectable activation; STREAM_NEURON_SAT_EN selects saturating narrowing
module stream_neuron
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3
) (
  input logic           clk,
  input logic           rst,
  stream_neuron_if.slave bus
);

  localparam int AW    = $clog2(NUM_INPUTS + 1);
  localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int ACC_W = acc_width(WIDTH, FRAC_BITS, NUM_INPUTS);

  localparam logic [AW-1:0]          BIAS_ADDR = AW'(NUM_INPUTS);
  localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_INPUTS - 1);
  localparam logic signed [WIDTH-1:0] POS_ONE  = WIDTH'(1 << FRAC_BITS);
  localparam logic signed [WIDTH-1:0] NEG_ONE  = -POS_ONE;
  localparam logic signed [WIDTH-1:0] MAX_V    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state, state_nxt;
  logic   ready_c, valid_c;

  logic signed [WIDTH-1:0] w_mem [NUM_INPUTS];
  logic signed [WIDTH-1:0] bias_reg;
  logic signed [WIDTH-1:0] bias_q;
  act_mode_e               act_mode_q;
  logic [IW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;

  logic beat, first, last;
  assign beat  = bus.valid_in && ready_c;
  assign first = beat && (state == IDLE);
  assign last  = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) w_mem[i] <= '0;
      bias_reg <= '0;
    end else if (state == IDLE && bus.weight_we) begin
      if (bus.weight_addr < BIAS_ADDR) w_mem[bus.weight_addr[IW-1:0]] <= bus.weight_data;
      else if (bus.weight_addr == BIAS_ADDR) bias_reg <= bus.weight_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      bias_q     <= '0;
      act_mode_q <= ACT_IDENTITY;
    end else begin
      if (beat) idx <= last ? '0 : idx + 1'b1;
      if (first) begin
        bias_q     <= bias_reg;
        act_mode_q <= act_mode_e'(bus.act_mode);
      end
    end
  end

  fxp_mac #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .mac_en  (beat),
    .load    (state == IDLE),
    .add_en  (state == BIAS),
    .a       (bus.value_in),
    .b       (w_mem[idx]),
    .add_val (ACC_W'(bias_q)),
    .acc     (acc)
  );

  // In range exactly when every bit above the narrowed sign bit copies it.
  logic [ACC_W-WIDTH:0]    hi;
  logic                    ovf;
  logic signed [WIDTH-1:0] narrowed;
  logic signed [WIDTH-1:0] act_v;

  always_comb begin
    hi  = acc[ACC_W-1:WIDTH-1];
    ovf = !((&hi) || !(|hi));
`ifdef STREAM_NEURON_SAT_EN
    narrowed = ovf ? (acc[ACC_W-1] ? MIN_V : MAX_V) : acc[WIDTH-1:0];
`else
    narrowed = acc[WIDTH-1:0];
`endif
    act_v = narrowed;
    case (act_mode_q)
      ACT_IDENTITY: act_v = narrowed;
      ACT_RELU:     act_v = narrowed[WIDTH-1] ? '0 : narrowed;
      ACT_HTANH: begin
        if (narrowed > POS_ONE)      act_v = POS_ONE;
        else if (narrowed < NEG_ONE) act_v = NEG_ONE;
        else                         act_v = narrowed;
      end
      ACT_LEAKY:    act_v = narrowed[WIDTH-1] ? (narrowed >>> LEAKY_SHIFT) : narrowed;
      default:      act_v = narrowed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.value_out <= '0;
      bus.overflow  <= 1'b0;
    end else if (state == ACT) begin
      bus.value_out <= act_v;
      bus.overflow  <= ovf;
    end else if (first) begin
      bus.overflow  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (beat) state_nxt = last ? BIAS : ACCUM;
      end
      ACCUM: begin
        ready_c = 1'b1;
        if (beat && last) state_nxt = BIAS;
      end
      BIAS: state_nxt = ACT;
      ACT:  state_nxt = DONE;
      DONE: begin
        valid_c = 1'b1;
        if (bus.ready_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready     = ready_c;
  assign bus.valid_out = valid_c;

endmodule

// File: tb/tb_stream_neuron.sv
// tb/tb_stream_neuron.sv - scoreboard bench for stream_neuron with directed and random vectors
module tb_stream_neuron;

  localparam int N = 8;

  typedef struct {
    int val;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_neuron_if #(.NUM_INPUTS(N), .WIDTH(8)) bus ();

  stream_neuron #(.NUM_INPUTS(N), .WIDTH(8), .FRAC_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  bit   rand_ro = 1'b0;
  bit   prev_v = 1'b0;
  exp_t exp_q[$];
  int   mw[N];
  int   mb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic from the neuron's definition.
  function automatic exp_t model(input int xs[N], input int mode);
    exp_t r;
    int   sum, v;
    sum = mb;
    for (int i = 0; i < N; i++) sum += (xs[i] * mw[i]) >>> 3;
    r.ovf = (sum > 127 || sum < -128) ? 1 : 0;
`ifdef STREAM_NEURON_SAT_EN
    v = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
`else
    v = sum & 255;
    if (v > 127) v -= 256;
`endif
    case (mode)
      1: r.val = (v < 0) ? 0 : v;
      2: r.val = (v > 8) ? 8 : (v < -8) ? -8 : v;
      3: r.val = (v < 0) ? (v >>> 3) : v;
      default: r.val = v;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rand_ro) bus.ready_out = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.valid_out && !prev_v) check("latency", cyc - last_acc_cyc, 2);
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("value_out", int'($signed(bus.value_out)), e.val);
          check("overflow", int'(bus.overflow), e.ovf);
        end
      end
      prev_v = bus.valid_out;
    end
  end

  task automatic write_w(input int addr, input int data, input bit land);
    @(negedge clk);
    bus.weight_we   = 1'b1;
    bus.weight_addr = 4'(addr);
    bus.weight_data = 8'(data);
    @(negedge clk);
    bus.weight_we = 1'b0;
    if (land) begin
      if (addr < N) mw[addr] = data;
      else if (addr == N) mb = data;
    end
  endtask

  task automatic set_weights(input int wv, input int bv);
    for (int i = 0; i < N; i++) write_w(i, wv, 1'b1);
    write_w(N, bv, 1'b1);
  endtask

  task automatic send_beat(input int x, input int mode, output bit ok);
    bit acc;
    int tries;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.value_in = 8'(x);
    bus.act_mode = 2'(mode);
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 300) begin
      acc = bus.ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
      else begin
        tries++;
        @(negedge clk);
      end
    end
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_vec(input int xs[N], input int mode, input int gap, input exp_t e);
    bit ok;
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) begin
      send_beat(xs[i], mode, ok);
      if (i == N - 1) last_acc_cyc = cyc;
      if (gap > 1) begin
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int v, input int o);
    exp_t e;
    e.val = v;
    e.ovf = o;
    return e;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   xs[N];
    int   hold_v, mode, gap;
    exp_t e;
    bit   ok;

    bus.weight_we = 0; bus.weight_addr = '0; bus.weight_data = '0;
    bus.act_mode = 0; bus.value_in = '0; bus.valid_in = 0; bus.ready_out = 1;
    foreach (mw[i]) mw[i] = 0;
    mb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", int'(bus.ready), 1);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_value_out", int'(bus.value_out), 0);
    check("rst_overflow", int'(bus.overflow), 0);

    set_weights(8, 0);
    foreach (xs[i]) xs[i] = 4;
    send_vec(xs, 0, 1, mk(32, 0));
    wait_idle();
    send_vec(xs, 2, 1, mk(8, 0));
    wait_idle();

    set_weights(-8, 0);
    foreach (xs[i]) xs[i] = 8;
    send_vec(xs, 1, 1, mk(0, 0));
    send_vec(xs, 3, 1, mk(-8, 0));
    send_vec(xs, 0, 1, mk(-64, 0));
    wait_idle();

    set_weights(127, 0);
    foreach (xs[i]) xs[i] = 127;
`ifdef STREAM_NEURON_SAT_EN
    send_vec(xs, 0, 1, mk(127, 1));
`else
    send_vec(xs, 0, 1, mk(0, 1));
`endif
    wait_idle();
    set_weights(8, 0);
    foreach (xs[i]) xs[i] = 4;
    send_vec(xs, 0, 1, mk(32, 0));
    wait_idle();

    // Held result: stall the collector and try a weight write while waiting.
    bus.ready_out = 1'b0;
    send_vec(xs, 0, 1, mk(32, 0));
    begin : wait_valid
      int t;
      t = 0;
      while (!bus.valid_out && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    hold_v = int'(bus.value_out);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.weight_we   = (k == 0);
      bus.weight_addr = 4'd0;
      bus.weight_data = 8'h7f;
      check("hold_valid", int'(bus.valid_out), 1);
      check("hold_value", int'(bus.value_out), hold_v);
      check("hold_ready", int'(bus.ready), 0);
    end
    @(negedge clk);
    bus.weight_we = 1'b0;
    bus.ready_out = 1'b1;
    wait_idle();
    send_vec(xs, 0, 1, mk(32, 0));
    wait_idle();

    // Abort mid-vector; nothing may come out of it.
    for (int i = 0; i < 3; i++) send_beat(4, 0, ok);
    @(negedge clk);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", int'(bus.ready), 1);
    check("abort_valid_out", int'(bus.valid_out), 0);
    check("abort_value_out", int'(bus.value_out), 0);
    check("abort_overflow", int'(bus.overflow), 0);
    foreach (mw[i]) mw[i] = 0;
    mb = 0;
    set_weights(8, 16);
    send_vec(xs, 0, 1, mk(48, 0));
    wait_idle();

    set_weights(8, 0);
    send_vec(xs, 0, 3, mk(32, 0));
    send_vec(xs, 0, 3, mk(32, 0));
    wait_idle();

    rand_ro = 1'b1;
    for (int v = 0; v < 30; v++) begin
      for (int i = 0; i < N; i++) write_w(i, int'($urandom_range(0, 255)) - 128, 1'b1);
      write_w(N, int'($urandom_range(0, 255)) - 128, 1'b1);
      if ($urandom_range(0, 3) == 0) write_w(N + 1 + int'($urandom_range(0, 6)), 99, 1'b0);
      foreach (xs[i]) xs[i] = int'($urandom_range(0, 255)) - 128;
      mode = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(1, 3));
      e = model(xs, mode);
      send_vec(xs, mode, gap, e);
      wait_idle();
    end
    rand_ro = 1'b0;
    bus.ready_out = 1'b1;
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
